sync_filter_edge: RTL and testbench

- Parametrised multi-channel input conditioner for asynchronous inputs such as buttons, switches and off-domain flags.
- Per channel, it chains an N-flop synchronizer, a consecutive-cycle stability filter (debounce) and a registered rise/fall pulse detector.
- Sits between top-level I/O pins and control logic, replacing bare 2-flop synchronizer instances where filtered state or edge events are needed.

---
 rtl/sync_filter_edge.sv | 74 +++++++
 tb/tb_sync_filter_edge.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_filter_edge.sv
// Per-channel input conditioner: N-flop synchronizer, consecutive-cycle debounce, registered rise/fall pulses.
// Latency: sync_out SYNC_STAGES cycles, stable_out/pulses SYNC_STAGES+STABLE_CYCLES cycles; no backpressure.
module sync_filter_edge #(
    parameter int               WIDTH         = 1,
    parameter int               SYNC_STAGES   = 2,
    parameter int               STABLE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    localparam int             CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

    // Plain flop chain: only sync_q[0] may sample a metastable value.
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= RESET_VAL;
            end
        end else begin
            sync_q[0] <= async_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    for (genvar c = 0; c < WIDTH; c++) begin : g_ch
        logic [CW-1:0] cnt;
        logic          stable_q;
        logic          rise_q;
        logic          fall_q;

        // Any cycle agreeing with the filtered level discards the run, so only
        // STABLE_CYCLES back-to-back disagreements can flip the level.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt      <= '0;
                stable_q <= RESET_VAL[c];
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (sync_out[c] == stable_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    stable_q <= sync_out[c];
                    cnt      <= '0;
                    rise_q   <= sync_out[c];
                    fall_q   <= ~sync_out[c];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign stable_out[c] = stable_q;
        assign rise_pulse[c] = rise_q;
        assign fall_pulse[c] = fall_q;
    end

endmodule

// File: tb/tb_sync_filter_edge.sv
// Bench for sync_filter_edge: two instances (2-ch default params, 1-ch sweep params) against a behavioural model.
module tb_sync_filter_edge;

    logic       clk;
    logic       rst;
    logic [1:0] a_in;
    logic [1:0] a_sync, a_stable, a_rise, a_fall;
    logic       b_in;
    logic       b_sync, b_stable, b_rise, b_fall;

    int n_checks = 0;
    int n_fail   = 0;

    sync_filter_edge #(
        .WIDTH(2), .SYNC_STAGES(2), .STABLE_CYCLES(4), .RESET_VAL(2'b00)
    ) u_a (
        .clk(clk), .rst(rst), .async_in(a_in),
        .sync_out(a_sync), .stable_out(a_stable),
        .rise_pulse(a_rise), .fall_pulse(a_fall)
    );

    sync_filter_edge #(
        .WIDTH(1), .SYNC_STAGES(3), .STABLE_CYCLES(1), .RESET_VAL(1'b1)
    ) u_b (
        .clk(clk), .rst(rst), .async_in(b_in),
        .sync_out(b_sync), .stable_out(b_stable),
        .rise_pulse(b_rise), .fall_pulse(b_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, index 0 = instance a, 1 = instance b.
    int         nst [2] = '{2, 3};
    int         sc  [2] = '{4, 1};
    int         wid [2] = '{2, 1};
    logic [1:0] rv  [2] = '{2'b00, 2'b01};

    logic [1:0] hist [2][$];
    logic [1:0] m_sync [2];
    logic [1:0] m_stable [2];
    logic [1:0] m_rise [2];
    logic [1:0] m_fall [2];
    int         m_run [2][2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // sync_out is the input seen nst edges ago; the level flips once sc
    // consecutive sampled sync values disagree with it.
    task automatic model_edge(input int k, input logic r, input logic [1:0] a);
        if (r) begin
            hist[k].delete();
            m_sync[k]   = rv[k];
            m_stable[k] = rv[k];
            m_rise[k]   = 2'b00;
            m_fall[k]   = 2'b00;
            m_run[k][0] = 0;
            m_run[k][1] = 0;
        end else begin
            m_rise[k] = 2'b00;
            m_fall[k] = 2'b00;
            for (int c = 0; c < wid[k]; c++) begin
                if (m_sync[k][c] != m_stable[k][c]) begin
                    m_run[k][c] = m_run[k][c] + 1;
                    if (m_run[k][c] == sc[k]) begin
                        m_stable[k][c] = m_sync[k][c];
                        m_rise[k][c]   = m_sync[k][c];
                        m_fall[k][c]   = ~m_sync[k][c];
                        m_run[k][c]    = 0;
                    end
                end else begin
                    m_run[k][c] = 0;
                end
            end
            hist[k].push_back(a);
            if (hist[k].size() > nst[k]) void'(hist[k].pop_front());
            m_sync[k] = (hist[k].size() == nst[k]) ? hist[k][0] : rv[k];
        end
    endtask

    task automatic step(input logic r, input logic [1:0] a, input logic b);
        rst  = r;
        a_in = a;
        b_in = b;
        @(posedge clk);
        model_edge(0, r, a);
        model_edge(1, r, {1'b0, b});
        @(negedge clk);
        check("a_sync",   a_sync,   m_sync[0]);
        check("a_stable", a_stable, m_stable[0]);
        check("a_rise",   a_rise,   m_rise[0]);
        check("a_fall",   a_fall,   m_fall[0]);
        check("b_sync",   {1'b0, b_sync},   m_sync[1]);
        check("b_stable", {1'b0, b_stable}, m_stable[1]);
        check("b_rise",   {1'b0, b_rise},   m_rise[1]);
        check("b_fall",   {1'b0, b_fall},   m_fall[1]);
    endtask

    initial begin
        int         first_a, first_b, second_b, n_a, n_b, n_x;
        logic [7:0] pat;
        logic [1:0] ra;
        logic       rb;

        rst  = 1'b1;
        a_in = 2'b11;
        b_in = 1'b0;

        // Reset with inputs high; release and time the first edges.
        repeat (3) step(1'b1, 2'b11, 1'b0);
        check("rst_a_stable", a_stable, 2'b00);
        check("rst_a_pulses", {a_rise, a_fall}, 4'b0000);
        check("rst_b_stable", b_stable, 1'b1);
        first_a = -1; first_b = -1; n_a = 0; n_b = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 2'b11, 1'b0);
            if (a_rise == 2'b11) begin
                n_a++;
                if (first_a < 0) first_a = i;
            end
            if (b_fall && first_b < 0) first_b = i;
            if (b_rise) n_b++;
        end
        check("rst_rise_edge", first_a, 6);
        check("rst_rise_count", n_a, 1);
        check("sweep_fall_edge", first_b, 4);
        check("sweep_no_rise", n_b, 0);

        // Clean press on ch0; one-cycle glitch on the sweep instance.
        repeat (8) step(1'b0, 2'b00, 1'b0);
        first_a = -1; first_b = -1; second_b = -1; n_a = 0; n_x = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 2'b01, (i == 1));
            if (a_sync[0] && first_a < 0) first_a = i;
            if (a_rise[0]) begin
                n_a++;
                check("press_rise_edge", i, 6);
            end
            if (a_fall != 2'b00) n_x++;
            if (b_rise && first_b < 0) first_b = i;
            if (b_fall && second_b < 0) second_b = i;
        end
        check("press_sync_edge", first_a, 2);
        check("press_rise_width", n_a, 1);
        check("press_no_fall", n_x, 0);
        check("glitch_rise_edge", first_b, 4);
        check("glitch_fall_edge", second_b, 5);

        // Bounce rejection, then a clean hold.
        repeat (8) step(1'b0, 2'b00, 1'b0);
        pat = 8'b0111_0111;
        n_x = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, {1'b0, pat[i]}, 1'b0);
            if (a_rise[0] || a_fall[0]) n_x++;
        end
        check("bounce_no_pulse", n_x, 0);
        check("bounce_stable", a_stable[0], 1'b0);
        first_a = -1;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 2'b01, 1'b0);
            if (a_rise[0] && first_a < 0) first_a = i;
        end
        check("bounce_hold_rise", first_a, 6);

        // ch0 falls while ch1 rises.
        n_a = 0; n_b = 0; n_x = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 2'b10, 1'b0);
            if (a_fall[0]) begin
                n_a++;
                check("indep_rise1", a_rise[1], 1'b1);
                check("indep_rise0", a_rise[0], 1'b0);
                check("indep_fall1", a_fall[1], 1'b0);
            end
            if (a_rise[1]) n_b++;
            if (a_rise[0] || a_fall[1]) n_x++;
        end
        check("indep_fall0_count", n_a, 1);
        check("indep_rise1_count", n_b, 1);
        check("indep_no_wrong", n_x, 0);

        // Reset mid-count discards the partial run.
        repeat (4) step(1'b0, 2'b11, 1'b0);
        step(1'b1, 2'b11, 1'b0);
        check("mid_rst_stable", a_stable, 2'b00);
        first_a = -1;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 2'b11, 1'b0);
            if (a_rise[0] && first_a < 0) first_a = i;
        end
        check("mid_rst_rise_edge", first_a, 6);

        // Randomised soak against the model.
        ra = 2'b00;
        rb = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) ra[0] = ~ra[0];
            if ($urandom_range(0, 5) == 0) ra[1] = ~ra[1];
            if ($urandom_range(0, 3) == 0) rb = ~rb;
            step(($urandom_range(0, 149) == 0), ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
